// File: rtl/result_bcd_converter.sv
// result_bcd_converter
//   Sequential double-dabble conversion of an unsigned binary magnitude into
//   packed BCD digits, with a sign flag and a leading-zero blanking mask for
//   a seven-segment style display.
//
// Parameters
//   N_IN   width of the unsigned binary input
//   N_DIG  number of BCD digits produced (10^N_DIG must exceed 2^N_IN - 1)
//
// Ports
//   Clk      system clock, rising edge
//   Reset_n  asynchronous active-low reset
//   Start    one-cycle conversion request, honoured only while idle
//   Value    magnitude to convert, captured with an accepted Start
//   Neg      sign of the result, captured with an accepted Start
//   Busy     high from Start acceptance until the Done pulse
//   Done     one-cycle pulse when Bcd/SignOut/Blank update
//   Bcd      packed BCD result, digit 0 in bits [3:0]
//   SignOut  sign of the completed result, never set for a zero magnitude
//   Blank    bit i set when digit i is a suppressible leading zero (bit 0 never)
module result_bcd_converter #(
  parameter int unsigned N_IN  = 17,
  parameter int unsigned N_DIG = 6
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic [N_IN-1:0]      Value,
  input  logic                 Neg,
  output logic                 Busy,
  output logic                 Done,
  output logic [4*N_DIG-1:0]   Bcd,
  output logic                 SignOut,
  output logic [N_DIG-1:0]     Blank
);

  localparam int unsigned      CNT_W     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N_IN - 1);
  localparam logic [N_DIG-1:0] BLANK_RST = {{(N_DIG-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t               state;
  logic [N_IN-1:0]      bin_sr;
  logic [4*N_DIG-1:0]   scratch;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_r;

  logic [4*N_DIG-1:0]   bcd_adj;
  logic [N_DIG-1:0]     blank_next;
  logic                 zero_run;

  // Add-3 correction applied to every scratch digit before each shift.
  always_comb begin
    bcd_adj = scratch;
    for (int unsigned d = 0; d < N_DIG; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask: walk from the top digit down while digits stay zero.
  // Digit 0 is excluded so a zero result still shows one "0".
  always_comb begin
    blank_next = '0;
    zero_run   = 1'b1;
    for (int unsigned j = 0; j + 1 < N_DIG; j++) begin
      zero_run = zero_run & (scratch[4*(N_DIG-1-j) +: 4] == 4'd0);
      blank_next[N_DIG-1-j] = zero_run;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      neg_r   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Bcd     <= '0;
      SignOut <= 1'b0;
      Blank   <= BLANK_RST;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            bin_sr  <= Value;
            scratch <= '0;
            neg_r   <= Neg;
            cnt     <= CNT_LAST;
            Busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          scratch <= {bcd_adj[4*N_DIG-2:0], bin_sr[N_IN-1]};
          bin_sr  <= bin_sr << 1;
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_DONE: begin
          Bcd     <= scratch;
          SignOut <= neg_r & (|scratch);
          Blank   <= blank_next;
          Done    <= 1'b1;
          Busy    <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
